// File: rtl/ram_frame_pkg.sv
// Shared types and defaults for the stream-to-RAM frame buffer controller.
// The controller alternates between filling the RAM and draining it back out.
package ram_frame_pkg;

    localparam int RF_ADDR_W = 2;
    localparam int RF_DATA_W = 8;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_frame_ctrl.sv
// Frame buffer controller: writes one frame of bytes into a single-port RAM,
// then reads it back in order; the RAM port is owned by exactly one phase at a time.
module ram_frame_ctrl
    import ram_frame_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam int                DEPTH    = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] w_len_nxt;
    logic              w_in_acc;
    logic              w_out_acc;
    logic              w_at_last;

    assign w_in_acc  = in_valid & in_ready;
    assign w_out_acc = out_valid & out_ready;
    assign w_at_last = (r_ptr == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_ptr   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // A frame closes on in_last or when the RAM is full; len keeps the index of the final byte.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        case (r_state)
            FILL: begin
                if (w_in_acc) begin
                    if (in_last || (r_ptr == LAST_IDX)) begin
                        w_len_nxt   = r_ptr;
                        w_ptr_nxt   = '0;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_out_acc) begin
                    if (w_at_last) begin
                        w_ptr_nxt   = '0;
                        w_state_nxt = FILL;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // in_ready is gated by rst_n so nothing is accepted or written while held in reset.
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        ram_wr_en   = 1'b0;
        ram_addr    = r_ptr;
        ram_wr_data = in_data;
        out_data    = ram_rd_data;
        case (r_state)
            FILL: begin
                in_ready  = rst_n;
                ram_wr_en = in_valid & rst_n;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_at_last;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/ram_frame_ctrl.md
Name: ram_frame_ctrl

Overview:
- Stream-to-RAM frame buffer controller; sits directly upstream of the single-port 4x8 RAM and drives its addr/wr_en/wr_data ports.
- Fills the RAM with one frame of bytes from an input valid/ready stream, then reads the frame back in order on an output valid/ready stream.
- Frames hold at most DEPTH bytes and end early on in_last.
- Alternates strictly between FILL and DRAIN, so the single RAM port is never shared within a cycle.

Parameters:
- ADDR_W, 2, RAM address width; DEPTH = 2**ADDR_W (4).
- DATA_W, 8, byte width of stream and RAM data.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream byte valid
- in_data  input  DATA_W  upstream byte
- in_last  input  1  marks final byte of frame (qualified by in_valid)
- in_ready  output  1  controller accepts byte this cycle
- out_valid  output  1  readback byte valid
- out_data  output  DATA_W  readback byte
- out_last  output  1  marks final byte of readback frame
- out_ready  input  1  downstream accepts byte
- busy  output  1  high while in DRAIN
- ram_addr  output  ADDR_W  to RAM addr
- ram_wr_en  output  1  to RAM wr_en
- ram_wr_data  output  DATA_W  to RAM wr_data
- ram_rd_data  input  DATA_W  from RAM rd_data (combinational read of ram_addr)

Behaviour:
- Reset (rst_n=0, async): state=FILL, ptr=0, len=0. Outputs while in reset: in_ready=0, out_valid=0, out_last=0, ram_wr_en=0, busy=0, ram_addr=0.
- Registers: state (FILL/DRAIN), ptr[ADDR_W-1:0], len[ADDR_W-1:0] (index of last byte written).
- FILL state:
  - in_ready=1 (after reset release); ram_addr=ptr; ram_wr_data=in_data.
  - ram_wr_en = in_valid & in_ready, combinational; the RAM writes at the same clk edge.
  - On accept with in_last=1 or ptr==DEPTH-1: len<=ptr, ptr<=0, state<=DRAIN.
  - Otherwise on accept: ptr<=ptr+1.
  - out_valid=0.
- DRAIN state:
  - in_ready=0, ram_wr_en=0, busy=1, ram_addr=ptr.
  - out_valid=1; out_data=ram_rd_data (zero added latency: same cycle as ram_addr).
  - out_last=(ptr==len).
  - On out_valid & out_ready & out_last: ptr<=0, state<=FILL.
  - Otherwise on out_valid & out_ready: ptr<=ptr+1.
  - Hold ptr when out_ready=0; out_data stays stable because the RAM is unchanged.
- Latency:
  - First readback byte is valid in the cycle after the final write edge.
  - FILL resumes in the cycle after the last byte is accepted downstream.
- Boundaries:
  - 1-byte frame (in_last on first byte): len=0, single out beat with out_last=1.
  - Full frame: ptr wraps DEPTH-1 -> 0 on the transition; in_last on that byte is redundant and harmless.
  - in_last with in_valid=0 is ignored.
  - out_ready held high gives one byte per cycle.
  - in_valid during DRAIN is not accepted and causes no RAM write.
- Reset mid-operation: state and pointers return to reset values immediately; RAM contents are not cleared; any partial frame is discarded.
- No arithmetic overflow: ptr increments are modulo DEPTH and never exceed len in DRAIN.

Decomposition:
- Shared package ram_frame_pkg:
  - state enum {FILL, DRAIN};
  - ADDR_W/DATA_W defaults;
  - DEPTH localparam function.
- No sub-module needed. Top-level test integration instantiates ram_frame_ctrl together with the 4x8 single-port RAM.

Test Plan:
- Full frame: in bytes 0x11,0x22,0x33,0x44 (in_valid continuous, out_ready=1).
  - Required: ram_wr_en 4 cycles at addr 0..3.
  - Required: out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, out_last only on 0x44.
- Short frame: 0xA5,0x5A with in_last on 0x5A.
  - Required: len=1; out 0xA5 then 0x5A (out_last=1).
  - Required: FILL resumes with in_ready=1 at ptr=0.
- Backpressure: out_ready toggling 1,0,0,1 during DRAIN of 0x01..0x04.
  - Required: out_data holds while out_ready=0, no byte skipped or duplicated.
  - Required: busy=1 throughout DRAIN.
- Input during DRAIN: hold in_valid=1 with 0xFF while draining.
  - Required: in_ready=0, ram_wr_en=0.
  - Required: next frame's first byte written at addr 0 after drain.
- Single-byte frame: 0x7E with in_last.
  - Required: one DRAIN cycle, out_valid=1, out_last=1, out_data=0x7E.
- Reset mid-DRAIN: assert rst_n=0 asynchronously after 2 of 4 beats.
  - Required: out_valid falls immediately, state=FILL, ptr=0 after release.
  - Required: next frame 0x10..0x13 reads back correctly.
